mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequencer and arbiter in front of the 15-bit-address, 12-bit-data main-memory RAM. It shares the single RAM port between the CPU and a data-break (DMA) channel. It forms the extended address from field plus 12-bit word address and sequences the RAM's one-cycle registered read. It also performs the three-cycle data-break increment (read, +1, write back) and flags accesses to non-existent memory.

## Interface
- DATA_WIDTH, 12, word width
- MAX_ADDRESS, 10239, highest implemented word address; must match the RAM instance
- BREAK_LIMIT, 4, consecutive break grants allowed while the CPU is waiting
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_field  in  3  instruction/data field
- cpu_addr  in  12  word address within field
- cpu_wdata  in  12  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  12  read data, valid when cpu_ack=1, held until next CPU read
- brk_req  in  1  data-break request, held until brk_ack
- brk_op  in  2  00 read, 01 write, 10 increment, 11 treated as read
- brk_field  in  3  field
- brk_addr  in  12  word address
- brk_wdata  in  12  write data
- brk_ack  out  1  one-cycle completion pulse
- brk_rdata  out  12  read data, or post-increment value for op 10
- brk_ovf  out  1  pulse with brk_ack when an increment wrapped to 0
- nxm  out  1  sticky non-existent-memory flag
- nxm_clr  in  1  clears nxm
- ram_addr  out  15  {field, addr} to RAM
- ram_din  out  12  RAM write data
- ram_we  out  1  RAM write enable
- ram_dout  in  12  RAM registered read data, valid the cycle after a read is issued

## Operation
- States: IDLE, ISSUE, RD_WAIT, INC_WR, ACK. The owner (CPU or BRK) and the operation are registered when leaving IDLE.
- IDLE: samples requests. Priority rules:
  - Break wins over CPU unless brk_count == BREAK_LIMIT and cpu_req=1; then CPU wins.
  - No request: stay in IDLE.
- brk_count:
  - Increments (saturating) on each break grant while cpu_req=1.
  - Clears on a CPU grant, or when cpu_req=0 in IDLE.
- ISSUE:
  - Drive ram_addr = {field, addr}.
  - Write: ram_we=1, ram_din=wdata, then go to ACK.
  - Read or increment: ram_we=0, then go to RD_WAIT.
- RD_WAIT:
  - Capture ram_dout into the owner's rdata (increment captures dout+1, 12-bit wrap).
  - Read goes to ACK; increment goes to INC_WR.
- INC_WR: ram_we=1, ram_din = captured value, latch ovf = (value==0), then go to ACK.
- ACK: owner's ack=1 (brk_ovf=ovf for break), go to IDLE. The requester drops req on the edge that ends ACK.
- Address rule: if {field, addr} > MAX_ADDRESS:
  - The access is still sequenced; the RAM drops the write.
  - Captured read data is forced to 0 (increment yields 1).
  - nxm sets at ISSUE.
  - If nxm set and nxm_clr occur in the same cycle, set wins.
- Outputs not owned by the current transfer hold their last value. ram_we=0 outside ISSUE/INC_WR.

## Timing
- Reset values: all outputs 0, state IDLE, brk_count 0, nxm 0. Reset is asynchronous, so ram_we drops immediately.
- Reset mid-transfer aborts the transfer: no ack. A pending increment write-back is lost.
- Latency, counted from the cycle req is seen in IDLE (cycle 0):
  - write: ram_we in cycle 1, ack in cycle 2
  - read: ack in cycle 3
  - increment: ram_we in cycle 3, ack in cycle 4
- Back-to-back requests: one IDLE cycle between transfers, so at least 3 cycles per write.
- A requester whose req is lost before grant is simply not served. Req deasserted after grant does not cancel the transfer.

## Configuration
- DATA_BREAK_EN defined: full two-port arbiter as above.
- Not defined:
  - brk_* inputs are ignored; brk_ack, brk_rdata and brk_ovf are tied 0.
  - INC_WR and brk_count are not built.
  - The CPU is the only requester, with unchanged latencies.

## Test plan
- CPU write 12'o1234 to field 1 addr 12'o0100, then read the same -> ram_addr 15'o10100, ack cycles 2 and 3, cpu_rdata 12'o1234.
- Break increment of a word holding 12'o7777 -> written value 0, brk_rdata 0, brk_ovf=1 with brk_ack in cycle 4.
- cpu_req and brk_req held continuously (BREAK_LIMIT=4) -> grant order B,B,B,B,C,B,B,B,B,C.
- Read field 3 addr 12'o0000 (15'o30000 > 10239) -> cpu_rdata 0, nxm=1. nxm_clr together with a new NXM access keeps nxm=1.
- reset_n pulsed low during INC_WR -> ram_we falls immediately, no brk_ack, memory word unchanged, all outputs 0.
- Built without DATA_BREAK_EN: brk_req=1 -> brk_ack stays 0 and CPU reads proceed with read ack in cycle 3.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU, data-break and RAM-port signal bundle for mem_arbiter
interface mem_arbiter_if #(parameter int DATA_WIDTH = 12);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [2:0]            cpu_field;
  logic [11:0]           cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_ack;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  brk_req;
  logic [1:0]            brk_op;
  logic [2:0]            brk_field;
  logic [11:0]           brk_addr;
  logic [DATA_WIDTH-1:0] brk_wdata;
  logic                  brk_ack;
  logic [DATA_WIDTH-1:0] brk_rdata;
  logic                  brk_ovf;
  logic                  nxm;
  logic                  nxm_clr;
  logic [14:0]           ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_dout;
  modport master (
    output cpu_req, cpu_we, cpu_field, cpu_addr, cpu_wdata,
    output brk_req, brk_op, brk_field, brk_addr, brk_wdata, nxm_clr, ram_dout,
    input  cpu_ack, cpu_rdata, brk_ack, brk_rdata, brk_ovf, nxm, ram_addr, ram_din, ram_we
  );
  modport slave (
    input  cpu_req, cpu_we, cpu_field, cpu_addr, cpu_wdata,
    input  brk_req, brk_op, brk_field, brk_addr, brk_wdata, nxm_clr, ram_dout,
    output cpu_ack, cpu_rdata, brk_ack, brk_rdata, brk_ovf, nxm, ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the main-memory RAM port between the CPU and the data-break channel.
// Define DATA_BREAK_EN to build the data-break channel; otherwise the CPU is the only requester.
module mem_arbiter #(
  parameter int DATA_WIDTH  = 12,
  parameter int MAX_ADDRESS = 10239,
  parameter int BREAK_LIMIT = 4
) (
  input logic          clk,
  input logic          reset_n,
  mem_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, RD_WAIT, INC_WR, ACK} state_t;
  localparam logic [14:0] MAX_A = 15'(MAX_ADDRESS);
  state_t                r_state, w_next;
  logic                  r_owner, r_we, r_inc, r_nxm;
  logic [14:0]           r_ram_addr;
  logic [DATA_WIDTH-1:0] r_din, r_cpu_rdata, w_rd_val;
  logic                  w_brk_win, w_grant, w_req_we, w_nxm, w_ram_we, w_cpu_ack;
  assign w_grant  = r_state == IDLE && (bus.cpu_req || w_brk_win);
  assign w_req_we = w_brk_win ? bus.brk_op == 2'b01 : bus.cpu_we;
  assign w_nxm    = r_ram_addr > MAX_A;
  assign w_rd_val = (w_nxm ? '0 : bus.ram_dout) + DATA_WIDTH'(r_inc);
  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Next-state: writes skip RD_WAIT, only increments visit INC_WR
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_grant ? ISSUE : IDLE;
      ISSUE:   w_next = r_we ? ACK : RD_WAIT;
`ifdef DATA_BREAK_EN
      RD_WAIT: w_next = r_inc ? INC_WR : ACK;
      INC_WR:  w_next = ACK;
`else
      RD_WAIT: w_next = ACK;
`endif
      default: w_next = IDLE;
    endcase
  end
  // Output decode: RAM write strobe and CPU completion pulse
  always_comb begin
    w_ram_we  = (r_state == ISSUE && r_we) || r_state == INC_WR;
    w_cpu_ack = r_state == ACK && !r_owner;
  end
  // Transfer context latched at grant, read capture, sticky NXM (set beats clear)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner     <= 1'b0;
      r_we        <= 1'b0;
      r_inc       <= 1'b0;
      r_ram_addr  <= '0;
      r_din       <= '0;
      r_cpu_rdata <= '0;
      r_nxm       <= 1'b0;
    end else begin
      if (w_grant) begin
        r_owner    <= w_brk_win;
        r_we       <= w_req_we;
        r_inc      <= w_brk_win && bus.brk_op == 2'b10;
        r_ram_addr <= w_brk_win ? {bus.brk_field, bus.brk_addr} : {bus.cpu_field, bus.cpu_addr};
        if (w_req_we) r_din <= w_brk_win ? bus.brk_wdata : bus.cpu_wdata;
      end
      if (r_state == RD_WAIT && !r_owner) r_cpu_rdata <= w_rd_val;
      if (r_state == RD_WAIT && r_inc) r_din <= w_rd_val;
      r_nxm <= (r_state == ISSUE && w_nxm) || (r_nxm && !bus.nxm_clr);
    end
  end
  assign bus.ram_we    = w_ram_we;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_din   = r_din;
  assign bus.cpu_ack   = w_cpu_ack;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.nxm       = r_nxm;
`ifdef DATA_BREAK_EN
  localparam int CW = $clog2(BREAK_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(BREAK_LIMIT);
  logic [CW-1:0]         r_brk_count;
  logic [DATA_WIDTH-1:0] r_brk_rdata;
  logic                  r_ovf;
  assign w_brk_win = bus.brk_req && !(bus.cpu_req && r_brk_count == LIMIT);
  // Break side: fairness count (cannot pass LIMIT while CPU waits), read data, wrap flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_brk_count <= '0;
      r_brk_rdata <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (r_state == IDLE) r_brk_count <= (bus.cpu_req && w_brk_win) ? r_brk_count + 1'b1 : '0;
      if (w_grant) r_ovf <= 1'b0;
      else if (r_state == INC_WR) r_ovf <= r_din == '0;
      if (r_state == RD_WAIT && r_owner) r_brk_rdata <= w_rd_val;
    end
  end
  assign bus.brk_ack   = r_state == ACK && r_owner;
  assign bus.brk_rdata = r_brk_rdata;
  assign bus.brk_ovf   = r_state == ACK && r_owner && r_ovf;
`else
  assign w_brk_win     = 1'b0;
  assign bus.brk_ack   = 1'b0;
  assign bus.brk_rdata = '0;
  assign bus.brk_ovf   = 1'b0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector bench for mem_arbiter with a behavioural RAM model
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  mem_arbiter_if bus();
  mem_arbiter dut(.clk(clk), .reset_n(reset_n), .bus(bus));
  logic [11:0] mem [0:32767];
  always @(posedge clk) begin
    bus.ram_dout <= (bus.ram_addr <= 15'd10239) ? mem[bus.ram_addr] : 12'o5252;
    if (bus.ram_we && bus.ram_addr <= 15'd10239) mem[bus.ram_addr] <= bus.ram_din;
  end
  int acks = 0, brk_acks = 0;
  always @(negedge clk) begin
    if (bus.cpu_ack || bus.brk_ack) acks++;
    if (bus.brk_ack) brk_acks++;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0o expected %0o", name, act, exp);
    end
  endtask
  function automatic logic [63:0] outs();
    return {8'd0, bus.ram_addr, bus.ram_din, bus.ram_we, bus.cpu_ack, bus.cpu_rdata,
            bus.brk_ack, bus.brk_rdata, bus.brk_ovf, bus.nxm};
  endfunction
  task automatic set_req(input logic brk, input logic [1:0] op, input logic [2:0] f,
                         input logic [11:0] a, input logic [11:0] d);
    if (brk) begin
      bus.brk_req = 1'b1; bus.brk_op = op; bus.brk_field = f; bus.brk_addr = a; bus.brk_wdata = d;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = op[0]; bus.cpu_field = f; bus.cpu_addr = a; bus.cpu_wdata = d;
    end
  endtask
  task automatic xfer(input logic brk, input logic [1:0] op, input logic [2:0] f, input logic [11:0] a,
                      input logic [11:0] d, output int ack_c, output int we_c, output logic [14:0] ra,
                      output logic [11:0] din, output logic [11:0] rd, output logic ovf);
    @(negedge clk);
    set_req(brk, op, f, a, d);
    ack_c = 0; we_c = 0; ra = '0; din = '0; rd = '0; ovf = 1'b0;
    for (int c = 1; c <= 12 && ack_c == 0; c++) begin
      @(negedge clk);
      if (c == 1) ra = bus.ram_addr;
      if (bus.ram_we && we_c == 0) begin we_c = c; din = bus.ram_din; end
      if (brk ? bus.brk_ack : bus.cpu_ack) begin
        ack_c = c;
        rd = brk ? bus.brk_rdata : bus.cpu_rdata;
        ovf = bus.brk_ovf;
      end
    end
    bus.cpu_req = 1'b0;
    bus.brk_req = 1'b0;
  endtask
  task automatic reset_abort(input logic brk, input logic [1:0] op, input logic [14:0] ad, input int we_cyc);
    int a0, ac, wc;
    logic [14:0] ra;
    logic [11:0] din, rd;
    logic ov;
    xfer(1'b0, 2'b01, ad[14:12], ad[11:0], 12'o0017, ac, wc, ra, din, rd, ov);
    @(negedge clk);
    set_req(brk, op, ad[14:12], ad[11:0], 12'o6543);
    repeat (we_cyc) @(negedge clk);
    chk("abort_we_before", bus.ram_we, 1);
    a0 = acks;
    reset_n = 1'b0;
    #1;
    chk("abort_we_async", bus.ram_we, 0);
    chk("abort_outs_zero", outs(), 0);
    bus.cpu_req = 1'b0;
    bus.brk_req = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_ack", acks - a0, 0);
    chk("abort_mem", mem[ad], 12'o0017);
  endtask
  typedef struct {
    logic        we;
    logic [2:0]  f;
    logic [11:0] a;
    logic [11:0] d;
    int          ack;
    int          wec;
    logic [14:0] ra;
    logic [11:0] rd;
    logic        nxm;
  } vec_t;
  vec_t vt [9];
  int ac, wc, b0;
  logic [14:0] ra;
  logic [11:0] din, rd;
  logic ov;
  string got;
  initial begin
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_field = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.brk_req = 0; bus.brk_op = 0; bus.brk_field = 0; bus.brk_addr = 0; bus.brk_wdata = 0;
    bus.nxm_clr = 0;
    vt[0] = '{1'b1, 3'd1, 12'o0100, 12'o1234, 2, 1, 15'o10100, 12'o0000, 1'b0};
    vt[1] = '{1'b0, 3'd1, 12'o0100, 12'o0000, 3, 0, 15'o10100, 12'o1234, 1'b0};
    vt[2] = '{1'b1, 3'd0, 12'o7777, 12'o0555, 2, 1, 15'o07777, 12'o1234, 1'b0};
    vt[3] = '{1'b0, 3'd0, 12'o7777, 12'o0000, 3, 0, 15'o07777, 12'o0555, 1'b0};
    vt[4] = '{1'b1, 3'd2, 12'o3777, 12'o4321, 2, 1, 15'o23777, 12'o0555, 1'b0};
    vt[5] = '{1'b0, 3'd2, 12'o3777, 12'o0000, 3, 0, 15'o23777, 12'o4321, 1'b0};
    vt[6] = '{1'b1, 3'd2, 12'o4000, 12'o7777, 2, 1, 15'o24000, 12'o4321, 1'b1};
    vt[7] = '{1'b0, 3'd2, 12'o4000, 12'o0000, 3, 0, 15'o24000, 12'o0000, 1'b1};
    vt[8] = '{1'b0, 3'd3, 12'o0000, 12'o0000, 3, 0, 15'o30000, 12'o0000, 1'b1};
    repeat (2) @(negedge clk);
    chk("reset_outs", outs(), 0);
    reset_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      xfer(1'b0, {1'b0, vt[i].we}, vt[i].f, vt[i].a, vt[i].d, ac, wc, ra, din, rd, ov);
      chk($sformatf("v%0d_ack_cycle", i), ac, vt[i].ack);
      chk($sformatf("v%0d_we_cycle", i), wc, vt[i].wec);
      chk($sformatf("v%0d_ram_addr", i), ra, vt[i].ra);
      chk($sformatf("v%0d_cpu_rdata", i), rd, vt[i].rd);
      chk($sformatf("v%0d_nxm", i), bus.nxm, vt[i].nxm);
      if (vt[i].we) chk($sformatf("v%0d_ram_din", i), din, vt[i].d);
    end
    @(negedge clk); bus.nxm_clr = 1'b1;
    @(negedge clk); bus.nxm_clr = 1'b0;
    chk("nxm_clear", bus.nxm, 0);
    @(negedge clk); set_req(1'b0, 2'b00, 3'd3, 12'o0000, 12'o0000);
    @(negedge clk); bus.nxm_clr = 1'b1;
    @(negedge clk); bus.nxm_clr = 1'b0;
    chk("nxm_set_beats_clr", bus.nxm, 1);
    @(negedge clk);
    chk("nxm_rd_ack", bus.cpu_ack, 1);
    chk("nxm_rd_data", bus.cpu_rdata, 0);
    bus.cpu_req = 1'b0;
`ifdef DATA_BREAK_EN
    xfer(1'b0, 2'b01, 3'd0, 12'o0200, 12'o7777, ac, wc, ra, din, rd, ov);
    xfer(1'b0, 2'b01, 3'd0, 12'o0201, 12'o0005, ac, wc, ra, din, rd, ov);
    @(negedge clk); bus.nxm_clr = 1'b1;
    @(negedge clk); bus.nxm_clr = 1'b0;
    xfer(1'b1, 2'b10, 3'd0, 12'o0200, 12'o0000, ac, wc, ra, din, rd, ov);
    chk("inc_wrap_ack", ac, 4);
    chk("inc_wrap_we", wc, 3);
    chk("inc_wrap_din", din, 0);
    chk("inc_wrap_rdata", rd, 0);
    chk("inc_wrap_ovf", ov, 1);
    chk("inc_wrap_mem", mem[15'o00200], 0);
    xfer(1'b1, 2'b10, 3'd0, 12'o0201, 12'o0000, ac, wc, ra, din, rd, ov);
    chk("inc_rdata", rd, 12'o0006);
    chk("inc_ovf", ov, 0);
    chk("inc_mem", mem[15'o00201], 12'o0006);
    xfer(1'b1, 2'b01, 3'd1, 12'o0300, 12'o2222, ac, wc, ra, din, rd, ov);
    chk("bwr_ack", ac, 2);
    chk("bwr_we", wc, 1);
    chk("bwr_din", din, 12'o2222);
    chk("bwr_addr", ra, 15'o10300);
    xfer(1'b1, 2'b11, 3'd1, 12'o0300, 12'o0000, ac, wc, ra, din, rd, ov);
    chk("brd11_ack", ac, 3);
    chk("brd11_we", wc, 0);
    chk("brd11_rdata", rd, 12'o2222);
    chk("binc_nxm_before", bus.nxm, 0);
    xfer(1'b1, 2'b10, 3'd3, 12'o0000, 12'o0000, ac, wc, ra, din, rd, ov);
    chk("binc_nxm_rdata", rd, 12'o0001);
    chk("binc_nxm_flag", bus.nxm, 1);
    @(negedge clk);
    set_req(1'b0, 2'b00, 3'd1, 12'o0100, 12'o0000);
    set_req(1'b1, 2'b00, 3'd1, 12'o0300, 12'o0000);
    got = "";
    for (int c = 0; c < 80 && got.len() < 10; c++) begin
      @(negedge clk);
      if (bus.brk_ack) got = {got, "B"};
      if (bus.cpu_ack) got = {got, "C"};
    end
    bus.cpu_req = 1'b0;
    bus.brk_req = 1'b0;
    checks++;
    if (got != "BBBBCBBBBC") begin
      failures++;
      $display("FAIL arb_order: got %s expected BBBBCBBBBC", got);
    end
    reset_abort(1'b1, 2'b10, 15'o00400, 3);
`else
    bus.brk_req = 1'b1; bus.brk_op = 2'b01; bus.brk_field = 3'd1; bus.brk_addr = 12'o0100; bus.brk_wdata = 0;
    b0 = brk_acks;
    xfer(1'b0, 2'b00, 3'd1, 12'o0100, 12'o0000, ac, wc, ra, din, rd, ov);
    chk("nobrk_cpu_ack", ac, 3);
    chk("nobrk_cpu_rdata", rd, 12'o1234);
    chk("nobrk_brk_ack", brk_acks - b0, 0);
    chk("nobrk_brk_rdata", bus.brk_rdata, 0);
    reset_abort(1'b0, 2'b01, 15'o00500, 1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
